// File: rtl/writeback_stage_pkg.sv
// Shared widths, register-zero constant and the WB slot record for the
// dual-issue writeback stage.
package writeback_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/wb_bypass_lane.sv
// One bypass lookup: a decode read address against the two WB write ports.
// The younger slot 2 wins when both match; register zero never hits.
module wb_bypass_lane
  import writeback_stage_pkg::ZERO_REG;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] data_1,
  input  logic              we_2,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] data_2,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rd_addr != ADDR_W'(ZERO_REG)) begin
      if (we_2 && (addr_2 == rd_addr)) begin
        hit  = 1'b1;
        data = data_2;
      end else if (we_1 && (addr_1 == rd_addr)) begin
        hit  = 1'b1;
        data = data_1;
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Dual-slot writeback stage: registers the two MEM results, drives the
// register-file write ports and serves zero-latency bypass to decode.
module writeback_stage
  import writeback_stage_pkg::ZERO_REG;
#(
  parameter int DATA_W = writeback_stage_pkg::DATA_W,
  parameter int ADDR_W = writeback_stage_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  MEM_Valid_1,
  input  logic                  MEM_Valid_2,
  input  logic                  MEM_Write_Enable_1,
  input  logic                  MEM_Write_Enable_2,
  input  logic [ADDR_W-1:0]     MEM_Write_Addr_1,
  input  logic [ADDR_W-1:0]     MEM_Write_Addr_2,
  input  logic [DATA_W-1:0]     MEM_Write_Data_1,
  input  logic [DATA_W-1:0]     MEM_Write_Data_2,
  input  logic [ADDR_W-1:0]     RS_Addr_1,
  input  logic [ADDR_W-1:0]     RT_Addr_1,
  input  logic [ADDR_W-1:0]     RS_Addr_2,
  input  logic [ADDR_W-1:0]     RT_Addr_2,
  output logic                  Write_Enable_1,
  output logic                  Write_Enable_2,
  output logic [ADDR_W-1:0]     Write_Addr_1,
  output logic [ADDR_W-1:0]     Write_Addr_2,
  output logic [DATA_W-1:0]     Write_Data_1,
  output logic [DATA_W-1:0]     Write_Data_2,
  output logic [3:0]            Fwd_Hit,
  output logic [4*DATA_W-1:0]   Fwd_Data,
  output logic [31:0]           Retired_Count
);

  // Same layout as the package record, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t       slot_1_q, slot_2_q;
  logic [31:0] retired_q;
  logic        en_1_raw, en_2;

  // Priority: reset, then Flush (only drops valid), then Stall (hold), then capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_1_q  <= '0;
      slot_2_q  <= '0;
      retired_q <= '0;
    end else if (Flush) begin
      slot_1_q.valid <= 1'b0;
      slot_2_q.valid <= 1'b0;
    end else if (!Stall) begin
      slot_1_q  <= '{MEM_Valid_1, MEM_Write_Enable_1, MEM_Write_Addr_1, MEM_Write_Data_1};
      slot_2_q  <= '{MEM_Valid_2, MEM_Write_Enable_2, MEM_Write_Addr_2, MEM_Write_Data_2};
      retired_q <= retired_q + 32'(MEM_Valid_1) + 32'(MEM_Valid_2);
    end
  end

  always_comb begin
    en_1_raw = slot_1_q.valid & slot_1_q.we & (slot_1_q.addr != ADDR_W'(ZERO_REG));
    en_2     = slot_2_q.valid & slot_2_q.we & (slot_2_q.addr != ADDR_W'(ZERO_REG));
  end

  // Slot 2 is the younger instruction, so it alone writes a shared destination.
  assign Write_Enable_1 = en_1_raw & ~(en_2 & (slot_1_q.addr == slot_2_q.addr));
  assign Write_Enable_2 = en_2;
  assign Write_Addr_1   = slot_1_q.addr;
  assign Write_Addr_2   = slot_2_q.addr;
  assign Write_Data_1   = slot_1_q.data;
  assign Write_Data_2   = slot_2_q.data;
  assign Retired_Count  = retired_q;

  logic [ADDR_W-1:0] rd_addr [4];
  assign rd_addr[0] = RS_Addr_1;
  assign rd_addr[1] = RT_Addr_1;
  assign rd_addr[2] = RS_Addr_2;
  assign rd_addr[3] = RT_Addr_2;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    wb_bypass_lane #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .rd_addr (rd_addr[i]),
      .we_1    (Write_Enable_1),
      .addr_1  (slot_1_q.addr),
      .data_1  (slot_1_q.data),
      .we_2    (Write_Enable_2),
      .addr_2  (slot_2_q.addr),
      .data_2  (slot_2_q.data),
      .hit     (Fwd_Hit[i]),
      .data    (Fwd_Data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a queue-based
// model of pending register writes.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, Stall, Flush;
  logic              MEM_Valid_1, MEM_Valid_2, MEM_Write_Enable_1, MEM_Write_Enable_2;
  logic [ADDR_W-1:0] MEM_Write_Addr_1, MEM_Write_Addr_2;
  logic [DATA_W-1:0] MEM_Write_Data_1, MEM_Write_Data_2;
  logic [ADDR_W-1:0] RS_Addr_1, RT_Addr_1, RS_Addr_2, RT_Addr_2;
  logic              Write_Enable_1, Write_Enable_2;
  logic [ADDR_W-1:0] Write_Addr_1, Write_Addr_2;
  logic [DATA_W-1:0] Write_Data_1, Write_Data_2;
  logic [3:0]        Fwd_Hit;
  logic [4*DATA_W-1:0] Fwd_Data;
  logic [31:0]       Retired_Count;

  writeback_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .MEM_Valid_1(MEM_Valid_1), .MEM_Valid_2(MEM_Valid_2),
    .MEM_Write_Enable_1(MEM_Write_Enable_1), .MEM_Write_Enable_2(MEM_Write_Enable_2),
    .MEM_Write_Addr_1(MEM_Write_Addr_1), .MEM_Write_Addr_2(MEM_Write_Addr_2),
    .MEM_Write_Data_1(MEM_Write_Data_1), .MEM_Write_Data_2(MEM_Write_Data_2),
    .RS_Addr_1(RS_Addr_1), .RT_Addr_1(RT_Addr_1), .RS_Addr_2(RS_Addr_2), .RT_Addr_2(RT_Addr_2),
    .Write_Enable_1(Write_Enable_1), .Write_Enable_2(Write_Enable_2),
    .Write_Addr_1(Write_Addr_1), .Write_Addr_2(Write_Addr_2),
    .Write_Data_1(Write_Data_1), .Write_Data_2(Write_Data_2),
    .Fwd_Hit(Fwd_Hit), .Fwd_Data(Fwd_Data), .Retired_Count(Retired_Count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  wb_slot_t    m_slot [2];
  logic [31:0] m_count;

  typedef struct {
    int                slot;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Called right after a posedge with the inputs that were sampled there.
  task automatic model_edge();
    if (reset) begin
      m_slot[0] = '0;
      m_slot[1] = '0;
      m_count   = 0;
    end else if (Flush) begin
      m_slot[0].valid = 1'b0;
      m_slot[1].valid = 1'b0;
    end else if (!Stall) begin
      m_slot[0] = '{MEM_Valid_1, MEM_Write_Enable_1, MEM_Write_Addr_1, MEM_Write_Data_1};
      m_slot[1] = '{MEM_Valid_2, MEM_Write_Enable_2, MEM_Write_Addr_2, MEM_Write_Data_2};
      m_count   = m_count + MEM_Valid_1 + MEM_Valid_2;
    end
  endtask

  task automatic check_all();
    wr_t               q [$];
    logic              exp_we [2];
    logic [3:0]        exp_hit;
    logic [4*DATA_W-1:0] exp_fwd;
    logic [ADDR_W-1:0] rd [4];
    rd[0] = RS_Addr_1; rd[1] = RT_Addr_1; rd[2] = RS_Addr_2; rd[3] = RT_Addr_2;
    // Pending writes in program order, register zero dropped.
    for (int k = 0; k < 2; k++)
      if (m_slot[k].valid && m_slot[k].we && m_slot[k].addr != 0)
        q.push_back('{k, m_slot[k].addr, m_slot[k].data});
    exp_we[0] = 1'b0;
    exp_we[1] = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      logic shadowed = 1'b0;
      for (int l = j + 1; l < q.size(); l++)
        if (q[l].addr == q[j].addr) shadowed = 1'b1;
      if (!shadowed) exp_we[q[j].slot] = 1'b1;
    end
    exp_hit = '0;
    exp_fwd = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd[i] != 0) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].addr == rd[i]) begin
            exp_hit[i] = 1'b1;
            exp_fwd[i*DATA_W +: DATA_W] = q[j].data;
            break;
          end
        end
      end
    end
    check("we_1",   Write_Enable_1, exp_we[0]);
    check("we_2",   Write_Enable_2, exp_we[1]);
    check("addr_1", Write_Addr_1,   m_slot[0].addr);
    check("addr_2", Write_Addr_2,   m_slot[1].addr);
    check("data_1", Write_Data_1,   m_slot[0].data);
    check("data_2", Write_Data_2,   m_slot[1].data);
    check("fwd_hit", Fwd_Hit,       exp_hit);
    check("fwd_data", Fwd_Data,     exp_fwd);
    check("retired", Retired_Count, m_count);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_mem(input logic v1, input logic we1, input logic [ADDR_W-1:0] a1,
                           input logic [DATA_W-1:0] d1, input logic v2, input logic we2,
                           input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
    MEM_Valid_1 = v1; MEM_Write_Enable_1 = we1; MEM_Write_Addr_1 = a1; MEM_Write_Data_1 = d1;
    MEM_Valid_2 = v2; MEM_Write_Enable_2 = we2; MEM_Write_Addr_2 = a2; MEM_Write_Data_2 = d2;
  endtask

  task automatic drive_rd(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rt1,
                          input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rt2);
    RS_Addr_1 = rs1; RT_Addr_1 = rt1; RS_Addr_2 = rs2; RT_Addr_2 = rt2;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive_mem(1, 1, 5'd7, 32'hDEAD_BEEF, 1, 1, 5'd8, 32'hCAFE_F00D);
    drive_rd(5'd7, 5'd8, 0, 0);
    m_slot[0] = '0; m_slot[1] = '0; m_count = 0;
    @(negedge clk);
    step();
    check("rst_we", {Write_Enable_2, Write_Enable_1}, 2'b00);
    check("rst_hit", Fwd_Hit, 4'h0);
    check("rst_count", Retired_Count, 32'd0);
    reset = 1'b0;

    // Two independent writes.
    drive_mem(1, 1, 5'd5, 32'h1111_1111, 1, 1, 5'd6, 32'h2222_2222);
    drive_rd(0, 0, 0, 0);
    step();
    check("cap_we", {Write_Enable_2, Write_Enable_1}, 2'b11);
    check("cap_addr", {Write_Addr_2, Write_Addr_1}, {5'd6, 5'd5});
    check("cap_count", Retired_Count, 32'd2);

    // Same destination in both slots.
    drive_mem(1, 1, 5'd9, 32'hA, 1, 1, 5'd9, 32'hB);
    drive_rd(5'd9, 0, 0, 0);
    step();
    check("conf_we", {Write_Enable_2, Write_Enable_1}, 2'b10);
    check("conf_hit0", Fwd_Hit[0], 1'b1);
    check("conf_lane0", Fwd_Data[31:0], 32'hB);

    // Register zero.
    drive_mem(1, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 32'h0);
    drive_rd(0, 0, 0, 0);
    step();
    check("zero_we1", Write_Enable_1, 1'b0);
    check("zero_hit", Fwd_Hit, 4'h0);
    check("zero_lane0", Fwd_Data[31:0], 32'h0);

    // Capture, hold through stall, then flush while stalled.
    drive_mem(1, 1, 5'd3, 32'h3333_3333, 0, 0, 5'd0, 32'h0);
    drive_rd(5'd3, 0, 0, 0);
    step();
    Stall = 1'b1;
    drive_mem(1, 1, 5'd12, 32'h1234_5678, 1, 1, 5'd13, 32'h9ABC_DEF0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr1", Write_Addr_1, 5'd3);
      check("stall_count", Retired_Count, 32'd6);
    end
    Flush = 1'b1;
    step();
    check("flush_we", {Write_Enable_2, Write_Enable_1}, 2'b00);
    check("flush_count", Retired_Count, 32'd6);

    // Reset while stalled with live slots.
    Flush = 1'b0; Stall = 1'b0;
    drive_mem(1, 1, 5'd4, 32'h4444_4444, 0, 1, 5'd5, 32'h5);
    step();
    check("pre_rst_count", Retired_Count, 32'd7);
    reset = 1'b1; Stall = 1'b1;
    drive_rd(5'd4, 5'd4, 5'd4, 5'd4);
    step();
    check("mid_rst_outs", {Write_Enable_1, Write_Enable_2, Write_Addr_1, Write_Addr_2,
                           Write_Data_1, Write_Data_2, Fwd_Hit}, '0);
    check("mid_rst_fwd", Fwd_Data, '0);
    check("mid_rst_count", Retired_Count, 32'd0);
    reset = 1'b0; Stall = 1'b0;

    // Counter wrap from a preloaded all-ones value.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_count = 32'hFFFF_FFFF;
    check("wrap_preload", Retired_Count, 32'hFFFF_FFFF);
    drive_mem(1, 0, 5'd1, 32'h1, 1, 0, 5'd2, 32'h2);
    step();
    check("wrap_count", Retired_Count, 32'd1);

    // Randomized traffic over a small address range to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) < 3);
      Flush = ($urandom_range(0, 99) < 10);
      Stall = ($urandom_range(0, 99) < 25);
      drive_mem($urandom_range(0, 1), $urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)), $urandom);
      drive_rd(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
               ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
